// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out a 4-bit amount as BIG/MID/1 coins over a valid/ready handshake.
// Optional coin tally output enabled by defining CHANGE_DISPENSER_TALLY_EN.
module change_dispenser #(
   parameter int BIG_COIN = 5,
   parameter int MID_COIN = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] diff,
   input  logic       coin_ready,
   output logic       coin_valid,
   output logic [1:0] coin_type,
   output logic       busy,
   output logic       done,
   output logic       reject
`ifdef CHANGE_DISPENSER_TALLY_EN
   ,
   output logic [3:0] coin_count
`endif
);

   // state    | meaning
   // IDLE     | waiting for start; refuses borrow with a reject pulse
   // DISPENSE | offering the greedy coin for the remaining amount
   // DONE     | one-cycle completion pulse, then back to IDLE
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      DONE     = 2'd2
   } state_t;

   localparam logic [3:0] BIG_V = 4'(BIG_COIN);
   localparam logic [3:0] MID_V = 4'(MID_COIN);

   state_t     state, state_nxt;
   logic [3:0] remaining, remaining_nxt;
   logic       reject_q, reject_nxt;
   logic [3:0] coin_val;
   logic       handshake;
   logic       start_ok;

   always_comb begin
      coin_type = 2'b00;
      coin_val  = 4'd0;
      if (state == DISPENSE) begin
         if (remaining >= BIG_V) begin
            coin_type = 2'b11;
            coin_val  = BIG_V;
         end else if (remaining >= MID_V) begin
            coin_type = 2'b10;
            coin_val  = MID_V;
         end else begin
            coin_type = 2'b01;
            coin_val  = 4'd1;
         end
      end
   end

   assign coin_valid = (state == DISPENSE);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign reject     = reject_q;
   assign handshake  = coin_valid && coin_ready;
   assign start_ok   = (state == IDLE) && start && !diff[4];

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      reject_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (diff[4]) begin
                  reject_nxt = 1'b1;
               end else if (diff[3:0] == 4'd0) begin
                  state_nxt = DONE;
               end else begin
                  remaining_nxt = diff[3:0];
                  state_nxt     = DISPENSE;
               end
            end
         end
         DISPENSE: begin
            if (handshake) begin
               // greedy decode guarantees coin_val <= remaining
               remaining_nxt = remaining - coin_val;
               if (remaining == coin_val) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt     = IDLE;
            remaining_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= 4'd0;
         reject_q  <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         reject_q  <= reject_nxt;
      end
   end

`ifdef CHANGE_DISPENSER_TALLY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         coin_count <= 4'd0;
      end else if (start_ok) begin
         coin_count <= 4'd0;
      end else if (handshake) begin
         coin_count <= coin_count + 4'd1;
      end
   end
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule
